positron_sequencer: RTL and testbench
=====================================

POSITRON_SEQUENCER -- requirements
Module: positron_sequencer

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 4, posit word width.
REQ-002 SHALL have parameter NB_UPSTREAM_POSITRON, default 784, words per window (>=1).
REQ-003 SHALL have parameter WIN_CNT_WIDTH, default 16, width of the window count.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: start_i in 1 command pulse; num_windows_i in WIN_CNT_WIDTH windows to run; busy_o out 1; done_o out 1 completion pulse.
REQ-006 SHALL have upstream ports: rts_i in 1; rtr_o out 1; posit_i in POSIT_WIDTH activation.
REQ-007 SHALL have positron-side ports: rts_o out 1; rtr_i in 1; sow_o out 1; eow_o out 1; posit_o out POSIT_WIDTH.
REQ-008 SHALL have result ports: res_rts_i in 1; res_eow_i in 1; res_posit_i in POSIT_WIDTH; res_rtr_o out 1.
REQ-009 SHALL have output ports: out_rts_o out 1; out_rtr_i in 1; out_posit_o out POSIT_WIDTH.

Function
REQ-010 SHALL implement FSM states IDLE, STREAM, WAIT_RES and DONE.
REQ-011 IDLE: start_i with num_windows_i!=0 SHALL latch the count into win_left, clear word_cnt and go to STREAM; start_i with 0 SHALL go to DONE.
REQ-012 start_i SHALL be ignored outside IDLE.
REQ-013 STREAM: rts_o=rts_i, rtr_o=rtr_i, posit_o=posit_i, all combinational (0-cycle latency).
REQ-014 STREAM: sow_o=(word_cnt==0), eow_o=(word_cnt==NB_UPSTREAM_POSITRON-1); with NB_UPSTREAM_POSITRON=1, both SHALL assert together.
REQ-015 A transfer occurs on rts_i&rtr_i in STREAM; word_cnt SHALL then increment, or on the eow word wrap to 0 and move to WAIT_RES.
REQ-016 Outside STREAM: rts_o=0, rtr_o=0, sow_o=0, eow_o=0.
REQ-017 WAIT_RES: res_rtr_o=out_rtr_i, out_rts_o=res_rts_i&res_eow_i, out_posit_o=res_posit_i.
REQ-018 WAIT_RES: res_rts_i without res_eow_i SHALL be consumed (res_rtr_o=1) and not forwarded.
REQ-019 A result transfer (res_rts_i&res_eow_i&out_rtr_i) SHALL decrement win_left; at 1 go to DONE, else go to STREAM.
REQ-020 Outside WAIT_RES: res_rtr_o=0 and out_rts_o=0.
REQ-021 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-022 busy_o SHALL be 1 in STREAM and WAIT_RES, else 0.
REQ-023 word_cnt SHALL be log2(NB_UPSTREAM_POSITRON) bits wide; win_left SHALL be WIN_CNT_WIDTH bits wide; neither counter SHALL wrap beyond its range.

Reset
REQ-024 Reset SHALL force IDLE, word_cnt=0 and win_left=0; all control outputs 0; posit_o and out_posit_o 0 when their handshakes are inactive.
REQ-025 Reset mid-window SHALL abandon the window; after reset the next start SHALL begin with sow_o on word 0.

Configuration
REQ-026 With POSITRON_SEQ_PERF_CNT_EN defined, port win_done_cnt_o out 32 SHALL count result transfers since reset, saturating at 2^32-1, reset 0.
REQ-027 Without POSITRON_SEQ_PERF_CNT_EN, neither the port nor the counter logic SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-028 The state typedef positron_seq_state_t SHALL reside in package posit_defines, which already provides log2.
REQ-029 The block SHALL be a single module with no sub-module; it SHALL instantiate no positron.

Verification
REQ-030 NB=4, start num_windows=2, rts_i/rtr_i held 1 -> sow_o on word 0, eow_o on word 3, WAIT_RES; two results -> two out transfers, done_o pulse 1 cycle, busy_o falls.
REQ-031 start with num_windows=0 -> done_o on the next cycle, no rts_o, busy_o stays 0.
REQ-032 NB=1, num_windows=3 -> sow_o=eow_o=1 on every word, 3 results forwarded.
REQ-033 rtr_i toggled 1,0,1 mid-window -> word_cnt holds while stalled, posit_o order preserved; out_rtr_i=0 in WAIT_RES -> res_rtr_o=0 and state held.
REQ-034 rst_n low at word 2 of 4 -> outputs 0 at once; new start -> sow_o on the first word.
REQ-035 POSITRON_SEQ_PERF_CNT_EN defined, 5 windows -> win_done_cnt_o=5; counter preset to 2^32-1 -> holds.

Source files
------------

// File: rtl/positron_sequencer_pkg.sv
// Shared definitions for the positron sequencer: the FSM state type and a
// ceiling log2 helper used to size counters.
package posit_defines;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } positron_seq_state_t;

    // Ceiling log2, never less than 1 so a single-word window still gets a
    // legal one-bit counter.
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/positron_sequencer.sv
// Positron sequencer: streams windows of NB_UPSTREAM_POSITRON posit words
// from an upstream source to a positron, then waits for each window's
// end-of-window result and forwards it downstream. Runs num_windows_i
// windows per start command.
// Optional feature macro: POSITRON_SEQ_PERF_CNT_EN adds win_done_cnt_o, a
// saturating count of forwarded results since reset.
module positron_sequencer
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH          = 4,
    parameter int NB_UPSTREAM_POSITRON = 784,
    parameter int WIN_CNT_WIDTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [WIN_CNT_WIDTH-1:0] num_windows_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     rts_i,
    output logic                     rtr_o,
    input  logic [POSIT_WIDTH-1:0]   posit_i,
    output logic                     rts_o,
    input  logic                     rtr_i,
    output logic                     sow_o,
    output logic                     eow_o,
    output logic [POSIT_WIDTH-1:0]   posit_o,
    input  logic                     res_rts_i,
    input  logic                     res_eow_i,
    input  logic [POSIT_WIDTH-1:0]   res_posit_i,
    output logic                     res_rtr_o,
    output logic                     out_rts_o,
    input  logic                     out_rtr_i,
    output logic [POSIT_WIDTH-1:0]   out_posit_o
`ifdef POSITRON_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]              win_done_cnt_o
`endif
);

    localparam int CNT_W = log2(NB_UPSTREAM_POSITRON);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NB_UPSTREAM_POSITRON - 1);

    positron_seq_state_t     state;
    positron_seq_state_t     next_state;
    logic [CNT_W-1:0]        word_cnt;
    logic [WIN_CNT_WIDTH-1:0] win_left;
    logic                    last_word;
    logic                    word_xfer;
    logic                    res_xfer;
    logic                    launch;

    assign last_word = (word_cnt == LAST_WORD);
    assign word_xfer = (state == STREAM) && rts_i && rtr_i;
    assign res_xfer  = (state == WAIT_RES) && res_rts_i && res_eow_i && out_rtr_i;
    assign launch    = (state == IDLE) && start_i && (num_windows_i != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and all handshake/status outputs.
    always_comb begin
        next_state  = state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        rts_o       = 1'b0;
        rtr_o       = 1'b0;
        sow_o       = 1'b0;
        eow_o       = 1'b0;
        posit_o     = '0;
        res_rtr_o   = 1'b0;
        out_rts_o   = 1'b0;
        out_posit_o = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = (num_windows_i != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                busy_o  = 1'b1;
                rts_o   = rts_i;
                rtr_o   = rtr_i;
                posit_o = posit_i;
                sow_o   = (word_cnt == '0);
                eow_o   = last_word;
                if (word_xfer && last_word) begin
                    next_state = WAIT_RES;
                end
            end
            WAIT_RES: begin
                busy_o      = 1'b1;
                // Intermediate (non end-of-window) results are drained here
                // and never reach the output port.
                res_rtr_o   = out_rtr_i || (res_rts_i && !res_eow_i);
                out_rts_o   = res_rts_i && res_eow_i;
                out_posit_o = res_posit_i;
                if (res_xfer) begin
                    next_state = (win_left == WIN_CNT_WIDTH'(1)) ? DONE : STREAM;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Word position within the window and remaining window count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            win_left <= '0;
        end else begin
            if (launch) begin
                word_cnt <= '0;
                win_left <= num_windows_i;
            end
            if (word_xfer) begin
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
            if (res_xfer && (win_left != '0)) begin
                win_left <= win_left - 1'b1;
            end
        end
    end

`ifdef POSITRON_SEQ_PERF_CNT_EN
    // Saturating count of results forwarded downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_done_cnt_o <= '0;
        end else if (res_xfer && (win_done_cnt_o != '1)) begin
            win_done_cnt_o <= win_done_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_positron_sequencer.sv
// Bench for positron_sequencer: one instance with 4-word windows and one
// with single-word windows; expected words/results queued by the stimulus,
// popped and compared by negedge monitors.
module tb_positron_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 4 words per window.
    logic       a_rst_n = 1'b0;
    logic       a_start_i = 1'b0;
    logic [15:0] a_num = '0;
    logic       a_busy_o, a_done_o;
    logic       a_rts_i = 1'b0, a_rtr_o;
    logic [3:0] a_posit_i = '0;
    logic       a_rts_o, a_rtr_i = 1'b0, a_sow_o, a_eow_o;
    logic [3:0] a_posit_o;
    logic       a_res_rts_i = 1'b0, a_res_eow_i = 1'b0;
    logic [3:0] a_res_posit_i = '0;
    logic       a_res_rtr_o, a_out_rts_o, a_out_rtr_i = 1'b0;
    logic [3:0] a_out_posit_o;

    // Instance B: 1 word per window.
    logic       b_rst_n = 1'b0;
    logic       b_start_i = 1'b0;
    logic [15:0] b_num = '0;
    logic       b_busy_o, b_done_o;
    logic       b_rts_i = 1'b0, b_rtr_o;
    logic [3:0] b_posit_i = '0;
    logic       b_rts_o, b_rtr_i = 1'b0, b_sow_o, b_eow_o;
    logic [3:0] b_posit_o;
    logic       b_res_rts_i = 1'b0, b_res_eow_i = 1'b0;
    logic [3:0] b_res_posit_i = '0;
    logic       b_res_rtr_o, b_out_rts_o, b_out_rtr_i = 1'b0;
    logic [3:0] b_out_posit_o;

`ifdef POSITRON_SEQ_PERF_CNT_EN
    logic [31:0] a_cnt, b_cnt;
`endif

    positron_sequencer #(.POSIT_WIDTH(4), .NB_UPSTREAM_POSITRON(4), .WIN_CNT_WIDTH(16)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .start_i(a_start_i), .num_windows_i(a_num),
        .busy_o(a_busy_o), .done_o(a_done_o),
        .rts_i(a_rts_i), .rtr_o(a_rtr_o), .posit_i(a_posit_i),
        .rts_o(a_rts_o), .rtr_i(a_rtr_i), .sow_o(a_sow_o), .eow_o(a_eow_o), .posit_o(a_posit_o),
        .res_rts_i(a_res_rts_i), .res_eow_i(a_res_eow_i), .res_posit_i(a_res_posit_i), .res_rtr_o(a_res_rtr_o),
        .out_rts_o(a_out_rts_o), .out_rtr_i(a_out_rtr_i), .out_posit_o(a_out_posit_o)
`ifdef POSITRON_SEQ_PERF_CNT_EN
        , .win_done_cnt_o(a_cnt)
`endif
    );

    positron_sequencer #(.POSIT_WIDTH(4), .NB_UPSTREAM_POSITRON(1), .WIN_CNT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .start_i(b_start_i), .num_windows_i(b_num),
        .busy_o(b_busy_o), .done_o(b_done_o),
        .rts_i(b_rts_i), .rtr_o(b_rtr_o), .posit_i(b_posit_i),
        .rts_o(b_rts_o), .rtr_i(b_rtr_i), .sow_o(b_sow_o), .eow_o(b_eow_o), .posit_o(b_posit_o),
        .res_rts_i(b_res_rts_i), .res_eow_i(b_res_eow_i), .res_posit_i(b_res_posit_i), .res_rtr_o(b_res_rtr_o),
        .out_rts_o(b_out_rts_o), .out_rtr_i(b_out_rtr_i), .out_posit_o(b_out_posit_o)
`ifdef POSITRON_SEQ_PERF_CNT_EN
        , .win_done_cnt_o(b_cnt)
`endif
    );

    // Expected word entries are {posit, sow, eow}; results are posit only.
    logic [5:0] aw_q[$];
    logic [3:0] ao_q[$];
    logic [5:0] bw_q[$];
    logic [3:0] bo_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Positron-side and output-side monitors for both instances.
    always @(negedge clk) begin : monitors
        logic [5:0] ew;
        logic [3:0] eo;
        if (a_rts_o && a_rtr_i) begin
            if (aw_q.size() == 0) chk("a_word_unexpected", 32'd1, 32'd0);
            else begin
                ew = aw_q.pop_front();
                chk("a_word", {26'd0, a_posit_o, a_sow_o, a_eow_o}, {26'd0, ew});
            end
        end
        if (a_out_rts_o && a_out_rtr_i) begin
            if (ao_q.size() == 0) chk("a_out_unexpected", 32'd1, 32'd0);
            else begin
                eo = ao_q.pop_front();
                chk("a_out", {28'd0, a_out_posit_o}, {28'd0, eo});
            end
        end
        if (b_rts_o && b_rtr_i) begin
            if (bw_q.size() == 0) chk("b_word_unexpected", 32'd1, 32'd0);
            else begin
                ew = bw_q.pop_front();
                chk("b_word", {26'd0, b_posit_o, b_sow_o, b_eow_o}, {26'd0, ew});
            end
        end
        if (b_out_rts_o && b_out_rtr_i) begin
            if (bo_q.size() == 0) chk("b_out_unexpected", 32'd1, 32'd0);
            else begin
                eo = bo_q.pop_front();
                chk("b_out", {28'd0, b_out_posit_o}, {28'd0, eo});
            end
        end
    end

    task automatic a_start(input int n);
        a_start_i = 1'b1;
        a_num = 16'(n);
        tick();
        a_start_i = 1'b0;
    endtask

    task automatic a_words(input int base);
        a_rts_i = 1'b1;
        a_rtr_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_posit_i = 4'(base + i);
            aw_q.push_back({4'(base + i), (i == 0), (i == 3)});
            tick();
        end
        a_rts_i = 1'b0;
        a_rtr_i = 1'b0;
    endtask

    task automatic a_result(input logic [3:0] p);
        ao_q.push_back(p);
        a_res_rts_i = 1'b1;
        a_res_eow_i = 1'b1;
        a_res_posit_i = p;
        a_out_rtr_i = 1'b1;
        tick();
        a_res_rts_i = 1'b0;
        a_res_eow_i = 1'b0;
        a_out_rtr_i = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // Idle after reset: everything quiet, data gated even with input driven.
        a_rts_i = 1'b1;
        a_posit_i = 4'h5;
        #1;
        chk("rst_busy", a_busy_o, 0);
        chk("rst_done", a_done_o, 0);
        chk("rst_rts_o", a_rts_o, 0);
        chk("rst_posit_o", a_posit_o, 0);
        chk("rst_res_rtr", a_res_rtr_o, 0);
        chk("rst_out_rts", a_out_rts_o, 0);
        a_rts_i = 1'b0;

        // Two windows of four words, with a non-eow result drained in between.
        a_start(2);
        chk("w2_busy_stream", a_busy_o, 1);
        a_words(1);
        chk("w2_busy_wait", a_busy_o, 1);
        chk("w2_rts_o_wait", a_rts_o, 0);
        a_res_rts_i = 1'b1;
        a_res_eow_i = 1'b0;
        a_res_posit_i = 4'hE;
        a_out_rtr_i = 1'b1;
        #1;
        chk("partial_res_rtr", a_res_rtr_o, 1);
        chk("partial_out_rts", a_out_rts_o, 0);
        tick();
        a_res_rts_i = 1'b0;
        a_out_rtr_i = 1'b0;
        chk("partial_still_wait", a_busy_o, 1);
        a_result(4'h9);
        chk("w2_back_stream_done", a_done_o, 0);
        a_words(5);
        a_result(4'hC);
        chk("w2_done_pulse", a_done_o, 1);
        chk("w2_busy_fall", a_busy_o, 0);
        tick();
        chk("w2_done_one_cycle", a_done_o, 0);

        // Zero windows: straight to a one-cycle done, never streams.
        a_rts_i = 1'b1;
        a_rtr_i = 1'b1;
        a_start(0);
        chk("zero_done", a_done_o, 1);
        chk("zero_busy", a_busy_o, 0);
        chk("zero_rts_o", a_rts_o, 0);
        tick();
        chk("zero_done_end", a_done_o, 0);
        a_rts_i = 1'b0;
        a_rtr_i = 1'b0;

        // Stall mid-window, then back-pressure on the result output.
        a_start(1);
        a_rts_i = 1'b1;
        a_rtr_i = 1'b1;
        a_posit_i = 4'd1;
        aw_q.push_back({4'd1, 1'b1, 1'b0});
        tick();
        a_rtr_i = 1'b0;
        a_posit_i = 4'd2;
        #1;
        chk("stall_rtr_o", a_rtr_o, 0);
        chk("stall_posit_o", a_posit_o, 4'd2);
        chk("stall_sow", a_sow_o, 0);
        tick();
        chk("stall_hold_eow", a_eow_o, 0);
        a_rtr_i = 1'b1;
        aw_q.push_back({4'd2, 1'b0, 1'b0});
        tick();
        a_posit_i = 4'd3;
        aw_q.push_back({4'd3, 1'b0, 1'b0});
        tick();
        a_posit_i = 4'd4;
        aw_q.push_back({4'd4, 1'b0, 1'b1});
        tick();
        a_rts_i = 1'b0;
        a_rtr_i = 1'b0;
        a_res_rts_i = 1'b1;
        a_res_eow_i = 1'b1;
        a_res_posit_i = 4'd7;
        a_out_rtr_i = 1'b0;
        #1;
        chk("bp_res_rtr", a_res_rtr_o, 0);
        chk("bp_out_rts", a_out_rts_o, 1);
        chk("bp_out_posit", a_out_posit_o, 4'd7);
        tick();
        chk("bp_held_busy", a_busy_o, 1);
        chk("bp_held_out_rts", a_out_rts_o, 1);
        ao_q.push_back(4'd7);
        a_out_rtr_i = 1'b1;
        tick();
        a_res_rts_i = 1'b0;
        a_res_eow_i = 1'b0;
        a_out_rtr_i = 1'b0;
        chk("bp_done", a_done_o, 1);
        tick();

        // Reset at word 2 of 4, then a fresh window starts at sow.
        a_start(1);
        a_rts_i = 1'b1;
        a_rtr_i = 1'b1;
        a_posit_i = 4'd3;
        aw_q.push_back({4'd3, 1'b1, 1'b0});
        tick();
        a_posit_i = 4'd4;
        aw_q.push_back({4'd4, 1'b0, 1'b0});
        tick();
        a_rst_n = 1'b0;
        a_posit_i = 4'd5;
        #1;
        chk("midrst_rts_o", a_rts_o, 0);
        chk("midrst_rtr_o", a_rtr_o, 0);
        chk("midrst_posit_o", a_posit_o, 0);
        chk("midrst_busy", a_busy_o, 0);
        a_rts_i = 1'b0;
        a_rtr_i = 1'b0;
        tick();
        a_rst_n = 1'b1;
        tick();
        a_start(1);
        a_words(10);
        a_result(4'h3);
        chk("postrst_done", a_done_o, 1);
        tick();
`ifdef POSITRON_SEQ_PERF_CNT_EN
        chk("a_perf_cnt", a_cnt, 32'd1);
`endif

        // Single-word windows: sow and eow together on every word.
        b_start_i = 1'b1;
        b_num = 16'd3;
        tick();
        b_start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_rts_i = 1'b1;
            b_rtr_i = 1'b1;
            b_posit_i = 4'(k + 1);
            bw_q.push_back({4'(k + 1), 1'b1, 1'b1});
            tick();
            b_rts_i = 1'b0;
            b_rtr_i = 1'b0;
            chk("b_wait_busy", b_busy_o, 1);
            bo_q.push_back(4'(k + 8));
            b_res_rts_i = 1'b1;
            b_res_eow_i = 1'b1;
            b_res_posit_i = 4'(k + 8);
            b_out_rtr_i = 1'b1;
            tick();
            b_res_rts_i = 1'b0;
            b_res_eow_i = 1'b0;
            b_out_rtr_i = 1'b0;
        end
        chk("b_done", b_done_o, 1);
        tick();
        chk("b_idle", b_busy_o, 0);
`ifdef POSITRON_SEQ_PERF_CNT_EN
        chk("b_perf_cnt", b_cnt, 32'd3);
`endif

        // Every queued expectation must have been consumed.
        tick();
        chk("aw_q_empty", aw_q.size(), 0);
        chk("ao_q_empty", ao_q.size(), 0);
        chk("bw_q_empty", bw_q.size(), 0);
        chk("bo_q_empty", bo_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
